// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
//   Bundles the signals between the shared-ALU arbiter and its environment.
//   The environment is the two requesters, the combinational ALU and the
//   response consumer.
//
//   Request side (per requester N = 0 EX stage, 1 address/branch unit):
//     reqN_valid/a/b/cntrl/setflags  -> arbiter
//     reqN_ready                     <- arbiter (granted this cycle)
//   ALU side:
//     alu_a/alu_b/alu_cntrl          <- arbiter (drive the shared ALU)
//     alu_result/alu_flags           -> arbiter (combinational ALU outputs)
//   Response side:
//     resp_valid/id/result/flags/err <- arbiter (registered, latency 1)
//   Status:
//     flags        architectural {N,Z,V,C}
//     stall_count  saturating count of cycles with a waiting request
//
//   Modports:
//     master : the environment (requesters, ALU, consumer)
//     slave  : the arbiter
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_cntrl;
    logic             req0_setflags;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_cntrl;
    logic             req1_setflags;
    logic             req1_ready;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cntrl;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic [3:0]       resp_flags;
    logic             resp_err;

    logic [3:0]       flags;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cntrl, req0_setflags,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cntrl, req1_setflags,
        input  req1_ready,
        input  alu_a, alu_b, alu_cntrl,
        output alu_result, alu_flags,
        input  resp_valid, resp_id, resp_result, resp_flags, resp_err,
        input  flags, stall_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cntrl, req0_setflags,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cntrl, req1_setflags,
        output req1_ready,
        output alu_a, alu_b, alu_cntrl,
        input  alu_result, alu_flags,
        output resp_valid, resp_id, resp_result, resp_flags, resp_err,
        output flags, stall_count
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (0 = EX stage,
//   1 = address/branch unit) with a round-robin grant. It registers the ALU
//   result as a one-cycle response and owns the architectural N/Z/V/C flags.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     stall  pipeline hold; no grant is issued while high
//     bus    alu_share_arbiter_if.slave (requests, ALU drive, response,
//            flag register, stall counter)
//
//   Timing:
//     grant / ready / ALU drive  combinational in cycle t
//     response, flags, rr ptr    updated at the edge ending cycle t
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    alu_share_arbiter_if.slave bus
);
    localparam logic [2:0] OP_PASSB = 3'b000;

    // Requester fields gathered into indexable form.
    logic [1:0]       req_valid;
    logic [WIDTH-1:0] req_a        [2];
    logic [WIDTH-1:0] req_b        [2];
    logic [2:0]       req_cntrl    [2];
    logic [1:0]       req_setflags;
    logic [1:0]       req_illegal;
    logic [1:0]       req_ready;

    // Combinational grant.
    logic             grant_any;
    logic             grant_id;

    // ALU drive.
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cntrl;

    // Registered state.
    logic             rr_q,          rr_d;
    logic             resp_valid_q,  resp_valid_d;
    logic             resp_id_q,     resp_id_d;
    logic [WIDTH-1:0] resp_result_q, resp_result_d;
    logic [3:0]       resp_flags_q,  resp_flags_d;
    logic             resp_err_q,    resp_err_d;
    logic [3:0]       flags_q,       flags_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign req_setflags = {bus.req1_setflags, bus.req0_setflags};
    assign req_a[0]     = bus.req0_a;
    assign req_a[1]     = bus.req1_a;
    assign req_b[0]     = bus.req0_b;
    assign req_b[1]     = bus.req1_b;
    assign req_cntrl[0] = bus.req0_cntrl;
    assign req_cntrl[1] = bus.req1_cntrl;

    // Per-requester decode: illegal op codes and ready.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_illegal[gi] = (req_cntrl[gi] == 3'b001) ||
                                     (req_cntrl[gi] == 3'b111);
            assign req_ready[gi]   = grant_any && (grant_id == 1'(gi));
        end
    endgenerate

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];

    // Grant: a lone requester always wins; on contention the round-robin
    // pointer picks the winner. Stall blocks everything.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (!stall) begin
            case (req_valid)
                2'b01: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b0;
                end
                2'b10: begin
                    grant_any = 1'b1;
                    grant_id  = 1'b1;
                end
                2'b11: begin
                    grant_any = 1'b1;
                    grant_id  = rr_q;
                end
                default: begin
                    grant_any = 1'b0;
                    grant_id  = 1'b0;
                end
            endcase
        end
    end

    // ALU drive. Idle cycles present zeros so the ALU inputs stay quiet.
    // Illegal ops are turned into passB; the response still reports the error.
    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_cntrl = OP_PASSB;
        if (grant_any) begin
            alu_a     = req_a[grant_id];
            alu_b     = req_b[grant_id];
            alu_cntrl = req_illegal[grant_id] ? OP_PASSB : req_cntrl[grant_id];
        end
    end

    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
    assign bus.alu_cntrl = alu_cntrl;

    // Next state for the response, the flag register, the rr pointer and the
    // stall counter.
    always_comb begin
        rr_d          = rr_q;
        resp_valid_d  = 1'b0;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        resp_err_d    = resp_err_q;
        flags_d       = flags_q;
        stall_count_d = stall_count_q;

        if (grant_any) begin
            // Hand priority to the other requester after every grant.
            rr_d          = ~grant_id;
            resp_valid_d  = 1'b1;
            resp_id_d     = grant_id;
            resp_result_d = bus.alu_result;
            resp_flags_d  = bus.alu_flags;
            resp_err_d    = req_illegal[grant_id];
            // An illegal op never touches the architectural flags, even if
            // it asked to.
            if (req_setflags[grant_id] && !req_illegal[grant_id]) begin
                flags_d = bus.alu_flags;
            end
        end

        // One count per cycle regardless of how many requesters wait;
        // the counter sticks at all-ones.
        if ((|(req_valid & ~req_ready)) && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q          <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            resp_err_q    <= 1'b0;
            flags_q       <= '0;
            stall_count_q <= '0;
        end else begin
            rr_q          <= rr_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            resp_err_q    <= resp_err_d;
            flags_q       <= flags_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_flags  = resp_flags_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.flags       = flags_q;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Drives two arbiter instances (CNT_W=16 and CNT_W=2) through a vector
//   table and a few hand-written multi-cycle sequences. A behavioural ALU
//   closes the loop from alu_* back to alu_result/alu_flags.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic stall = 1'b0;
    logic stall2 = 1'b0;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.WIDTH(64), .CNT_W(16)) bus ();
    alu_share_arbiter_if #(.WIDTH(64), .CNT_W(2))  bus2 ();

    alu_share_arbiter #(.WIDTH(64), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus)
    );

    alu_share_arbiter #(.WIDTH(64), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .stall (stall2),
        .bus   (bus2)
    );

    // Behavioural ALU: returns {N, Z, V, C, result}. Subtract is a + ~b + 1,
    // so C=1 means no borrow. Unknown codes give a marker value so that a
    // leaked illegal op shows up in the result.
    function automatic logic [67:0] alu_model(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input logic [2:0]  op);
        logic [64:0] s;
        logic [63:0] r;
        logic        v;
        logic        c;
        s = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                s = {1'b0, a} + {1'b0, ~b} + 65'd1;
                r = s[63:0];
                c = s[64];
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = 64'hDEAD_BEEF_DEAD_BEEF;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    assign {bus.alu_flags, bus.alu_result}   = alu_model(bus.alu_a, bus.alu_b, bus.alu_cntrl);
    assign {bus2.alu_flags, bus2.alu_result} = alu_model(bus2.alu_a, bus2.alu_b, bus2.alu_cntrl);

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        tests++;
        if (act !== req_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, req_v);
        end
    endtask

    // Scoreboard of expected responses.
    typedef struct {
        logic        id;
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
    } resp_t;

    resp_t sb_q[$];

    task automatic sb_push(input logic id, input logic [63:0] res,
                           input logic [3:0] fl, input logic err);
        resp_t e;
        e.id  = id;
        e.res = res;
        e.fl  = fl;
        e.err = err;
        sb_q.push_back(e);
    endtask

    // Called #1 after a rising edge.
    task automatic resp_check(input string tag);
        resp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, ".resp_valid"},  64'(bus.resp_valid),  64'd1);
            chk({tag, ".resp_id"},     64'(bus.resp_id),     64'(e.id));
            chk({tag, ".resp_result"}, bus.resp_result,      e.res);
            chk({tag, ".resp_flags"},  64'(bus.resp_flags),  64'(e.fl));
            chk({tag, ".resp_err"},    64'(bus.resp_err),    64'(e.err));
            $display("[TB] %s resp id=%0d result=%h flags=%b err=%0d",
                     tag, bus.resp_id, bus.resp_result, bus.resp_flags, bus.resp_err);
        end else begin
            chk({tag, ".resp_valid_idle"}, 64'(bus.resp_valid), 64'd0);
        end
    endtask

    task automatic set_req0(input logic v, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] c, input logic sf);
        bus.req0_valid    = v;
        bus.req0_a        = a;
        bus.req0_b        = b;
        bus.req0_cntrl    = c;
        bus.req0_setflags = sf;
    endtask

    task automatic set_req1(input logic v, input logic [63:0] a, input logic [63:0] b,
                            input logic [2:0] c, input logic sf);
        bus.req1_valid    = v;
        bus.req1_a        = a;
        bus.req1_b        = b;
        bus.req1_cntrl    = c;
        bus.req1_setflags = sf;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.resp_valid",  64'(bus.resp_valid),  64'd0);
        chk("rst.flags",       64'(bus.flags),       64'd0);
        chk("rst.stall_count", 64'(bus.stall_count), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One table row = one clock cycle.
    typedef struct {
        logic        st;
        logic        v0;
        logic [63:0] a0;
        logic [63:0] b0;
        logic [2:0]  c0;
        logic        sf0;
        logic        v1;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [2:0]  c1;
        logic        sf1;
        logic        r0;
        logic        r1;
        logic [2:0]  alu_c;
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
        logic [3:0]  flreg;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 17;
    vec_t tv [NV];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          st    v0   a0                     b0      c0     sf0   v1   a1       b1       c1     sf1   r0   r1   alu_c  res                    fl       err   flreg    cnt
        tv[0]  = '{1'b0, 1'b1, 64'd5,                64'd7,  3'b010, 1'b1, 1'b0, 64'd0,   64'd0,   3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 64'd12,               4'b0000, 1'b0, 4'b0000, 16'd0};
        tv[1]  = '{1'b0, 1'b1, 64'd1,                64'd2,  3'b010, 1'b0, 1'b1, 64'hF0,  64'hFF,  3'b110, 1'b0, 1'b0, 1'b1, 3'b110, 64'h0F,               4'b0000, 1'b0, 4'b0000, 16'd1};
        tv[2]  = '{1'b0, 1'b1, 64'd1,                64'd2,  3'b010, 1'b0, 1'b0, 64'd0,   64'd0,   3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 64'd3,                4'b0000, 1'b0, 4'b0000, 16'd1};
        tv[3]  = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'd5,   64'd5,   3'b011, 1'b0, 1'b0, 1'b1, 3'b011, 64'd0,                4'b0101, 1'b0, 4'b0000, 16'd1};
        tv[4]  = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'd5,   64'd5,   3'b011, 1'b1, 1'b0, 1'b1, 3'b011, 64'd0,                4'b0101, 1'b0, 4'b0101, 16'd1};
        tv[5]  = '{1'b1, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'hFF,  64'h0F,  3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0,                4'b0000, 1'b0, 4'b0101, 16'd2};
        tv[6]  = '{1'b1, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'hFF,  64'h0F,  3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0,                4'b0000, 1'b0, 4'b0101, 16'd3};
        tv[7]  = '{1'b1, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'hFF,  64'h0F,  3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0,                4'b0000, 1'b0, 4'b0101, 16'd4};
        tv[8]  = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'hFF,  64'h0F,  3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 64'h0F,               4'b0000, 1'b0, 4'b0101, 16'd4};
        tv[9]  = '{1'b0, 1'b1, 64'd9,                64'd3,  3'b111, 1'b1, 1'b0, 64'd0,   64'd0,   3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 64'd3,                4'b0000, 1'b1, 4'b0101, 16'd4};
        tv[10] = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'd7,   64'd0,   3'b001, 1'b1, 1'b0, 1'b1, 3'b000, 64'd0,                4'b0100, 1'b1, 4'b0101, 16'd4};
        tv[11] = '{1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 1'b0, 64'd0, 64'd0,  3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 64'h8000_0000_0000_0000, 4'b1010, 1'b0, 4'b1010, 16'd4};
        tv[12] = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b1, 64'd0,   64'd1,   3'b011, 1'b1, 1'b0, 1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b0, 4'b1000, 16'd4};
        tv[13] = '{1'b0, 1'b0, 64'd0,                64'd0,  3'b000, 1'b0, 1'b0, 64'd0,   64'd0,   3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 64'd0,                4'b0000, 1'b0, 4'b1000, 16'd4};
        tv[14] = '{1'b0, 1'b1, 64'd0,                64'h1234, 3'b000, 1'b0, 1'b1, 64'hFF, 64'hF0, 3'b100, 1'b0, 1'b1, 1'b0, 3'b000, 64'h1234,             4'b0000, 1'b0, 4'b1000, 16'd5};
        tv[15] = '{1'b0, 1'b1, 64'd3,                64'd3,  3'b110, 1'b1, 1'b1, 64'hFF,  64'hF0,  3'b100, 1'b0, 1'b0, 1'b1, 3'b100, 64'hF0,               4'b0000, 1'b0, 4'b1000, 16'd6};
        tv[16] = '{1'b0, 1'b1, 64'd3,                64'd3,  3'b110, 1'b1, 1'b0, 64'd0,   64'd0,   3'b000, 1'b0, 1'b1, 1'b0, 3'b110, 64'd0,                4'b0100, 1'b0, 4'b0100, 16'd6};

        set_req0(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        set_req1(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        bus2.req0_valid = 1'b0; bus2.req0_a = '0; bus2.req0_b = '0;
        bus2.req0_cntrl = 3'b000; bus2.req0_setflags = 1'b0;
        bus2.req1_valid = 1'b0; bus2.req1_a = '0; bus2.req1_b = '0;
        bus2.req1_cntrl = 3'b000; bus2.req1_setflags = 1'b0;

        do_reset();

        // ---- Asynchronous reset drops a pending response -------------------
        @(negedge clk);
        set_req0(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1);
        set_req1(1'b1, 64'd1, 64'd2, 3'b101, 1'b0);
        #1;
        chk("t1.ready0", 64'(bus.req0_ready), 64'd1);
        sb_push(1'b0, 64'h8000_0000_0000_0000, 4'b1010, 1'b0);
        @(posedge clk); #1;
        resp_check("t1.c0");
        chk("t1.flags",       64'(bus.flags),       64'd10);
        chk("t1.stall_count", 64'(bus.stall_count), 64'd1);
        @(negedge clk);
        set_req0(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        #1;
        chk("t1.ready1", 64'(bus.req1_ready), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1.async.resp_valid",  64'(bus.resp_valid),  64'd0);
        chk("t1.async.resp_id",     64'(bus.resp_id),     64'd0);
        chk("t1.async.resp_result", bus.resp_result,      64'd0);
        chk("t1.async.resp_flags",  64'(bus.resp_flags),  64'd0);
        chk("t1.async.flags",       64'(bus.flags),       64'd0);
        chk("t1.async.stall_count", 64'(bus.stall_count), 64'd0);
        set_req1(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        resp_check("t1.after");

        // ---- Contention straight after reset: grant 0 then 1 ---------------
        @(negedge clk);
        set_req0(1'b1, 64'd1, 64'd1, 3'b010, 1'b0);
        set_req1(1'b1, 64'd1, 64'd2, 3'b101, 1'b0);
        #1;
        chk("t3.c0.ready0", 64'(bus.req0_ready), 64'd1);
        chk("t3.c0.ready1", 64'(bus.req1_ready), 64'd0);
        sb_push(1'b0, 64'd2, 4'b0000, 1'b0);
        @(posedge clk); #1;
        resp_check("t3.c0");
        @(negedge clk);
        set_req0(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        #1;
        chk("t3.c1.ready1", 64'(bus.req1_ready), 64'd1);
        sb_push(1'b1, 64'd3, 4'b0000, 1'b0);
        @(posedge clk); #1;
        resp_check("t3.c1");
        chk("t3.stall_count", 64'(bus.stall_count), 64'd1);
        @(negedge clk);
        set_req1(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);

        do_reset();

        // ---- Vector table ----------------------------------------------------
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall = tv[i].st;
            set_req0(tv[i].v0, tv[i].a0, tv[i].b0, tv[i].c0, tv[i].sf0);
            set_req1(tv[i].v1, tv[i].a1, tv[i].b1, tv[i].c1, tv[i].sf1);
            #1;
            $display("[TB] vec %0d stall=%0d v0=%0d v1=%0d ready0=%0d ready1=%0d alu_cntrl=%b",
                     i, stall, bus.req0_valid, bus.req1_valid, bus.req0_ready, bus.req1_ready, bus.alu_cntrl);
            chk($sformatf("v%0d.ready0", i),    64'(bus.req0_ready), 64'(tv[i].r0));
            chk($sformatf("v%0d.ready1", i),    64'(bus.req1_ready), 64'(tv[i].r1));
            chk($sformatf("v%0d.alu_cntrl", i), 64'(bus.alu_cntrl),  64'(tv[i].alu_c));
            if (tv[i].r0) chk($sformatf("v%0d.alu_a", i), bus.alu_a, tv[i].a0);
            else if (tv[i].r1) chk($sformatf("v%0d.alu_a", i), bus.alu_a, tv[i].a1);
            else begin
                chk($sformatf("v%0d.alu_a_idle", i), bus.alu_a, 64'd0);
                chk($sformatf("v%0d.alu_b_idle", i), bus.alu_b, 64'd0);
            end
            if (tv[i].r0 || tv[i].r1) sb_push(tv[i].r1, tv[i].res, tv[i].fl, tv[i].err);
            @(posedge clk); #1;
            resp_check($sformatf("v%0d", i));
            chk($sformatf("v%0d.flags", i),       64'(bus.flags),       64'(tv[i].flreg));
            chk($sformatf("v%0d.stall_count", i), 64'(bus.stall_count), 64'(tv[i].cnt));
        end
        @(negedge clk);
        stall = 1'b0;
        set_req0(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);
        set_req1(1'b0, 64'd0, 64'd0, 3'b000, 1'b0);

        // ---- CNT_W=2 saturation, then an illegal op -------------------------
        @(negedge clk);
        stall2 = 1'b1;
        bus2.req1_valid = 1'b1; bus2.req1_a = 64'd9; bus2.req1_b = 64'd3;
        bus2.req1_cntrl = 3'b111; bus2.req1_setflags = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            $display("[TB] sat cycle %0d stall_count=%0d", k, bus2.stall_count);
            chk($sformatf("t6.cnt%0d", k), 64'(bus2.stall_count), 64'((k < 3) ? k : 3));
            chk($sformatf("t6.resp_valid%0d", k), 64'(bus2.resp_valid), 64'd0);
        end
        @(negedge clk);
        stall2 = 1'b0;
        #1;
        chk("t6.ready1",    64'(bus2.req1_ready), 64'd1);
        chk("t6.alu_cntrl", 64'(bus2.alu_cntrl),  64'd0);
        @(posedge clk); #1;
        $display("[TB] t6 resp valid=%0d err=%0d result=%h", bus2.resp_valid, bus2.resp_err, bus2.resp_result);
        chk("t6.resp_valid",  64'(bus2.resp_valid),  64'd1);
        chk("t6.resp_id",     64'(bus2.resp_id),     64'd1);
        chk("t6.resp_err",    64'(bus2.resp_err),    64'd1);
        chk("t6.resp_result", bus2.resp_result,      64'd3);
        chk("t6.flags",       64'(bus2.flags),       64'd0);
        chk("t6.stall_count", 64'(bus2.stall_count), 64'd3);
        @(negedge clk);
        bus2.req1_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
